// File: rtl/if_id_stage.sv
// Fetch stage + IF/ID pipeline register.
// Owns the PC, issues word fetches on a req/ack port and presents
// instruction + PC+4 to decode. Handles stall, flush and redirects that
// land while a fetch is still outstanding.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_FETCH | request pc; accept, buffer or redirect on ack
//   S_DROP  | redirect pending; keep old address until ack, then discard
//   S_HOLD  | fetched word parked in buffer while decode is stalled
//
// A flush (without a redirect) squashes IF/ID and also discards any word
// fetched or buffered in the same cycle; pc is left alone so that word is
// fetched again rather than skipped.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instrOUT,
  output logic [31:0] nextPcOUT,
  output logic        validOUT
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_target;
  logic [31:0] r_instr;
  logic [31:0] r_next_pc;
  logic        r_valid;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_target_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_next_pc_nxt;
  logic        w_valid_nxt;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = branch_target & ~32'h0000_0003;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign instrOUT  = r_instr;
  assign nextPcOUT = r_next_pc;
  assign validOUT  = r_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; redirect and flush outrank stall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (branch_taken)           w_state_nxt = imem_ack ? S_FETCH : S_DROP;
        else if (flush)             w_state_nxt = S_FETCH;
        else if (imem_ack && stall) w_state_nxt = S_HOLD;
        else                        w_state_nxt = S_FETCH;
      end
      S_DROP: begin
        if (imem_ack) w_state_nxt = S_FETCH;
      end
      S_HOLD: begin
        if (branch_taken || flush || !stall) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Memory port outputs; address is the PC, so it stays put through DROP
  always_comb begin
    imem_req  = (r_state != S_HOLD);
    imem_addr = r_pc;
  end

  // Datapath next values: pc, buffer, saved target and IF/ID contents
  always_comb begin
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_target_nxt  = r_target;
    w_instr_nxt   = r_instr;
    w_next_pc_nxt = r_next_pc;
    w_valid_nxt   = r_valid;
    case (r_state)
      S_FETCH: begin
        if (branch_taken) begin
          w_valid_nxt = 1'b0;
          if (imem_ack) w_pc_nxt     = w_target;
          else          w_target_nxt = w_target;
        end else if (flush) begin
          w_pc_nxt = r_pc;
        end else if (imem_ack) begin
          if (stall) begin
            w_buf_nxt = imem_rdata;
          end else begin
            w_instr_nxt   = imem_rdata;
            w_next_pc_nxt = w_pc_plus4;
            w_valid_nxt   = 1'b1;
            w_pc_nxt      = w_pc_plus4;
          end
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          if (imem_ack) w_pc_nxt     = w_target;
          else          w_target_nxt = w_target;
        end else if (imem_ack) begin
          w_pc_nxt = r_target;
        end
        if (branch_taken || !stall) w_valid_nxt = 1'b0;
      end
      S_HOLD: begin
        if (branch_taken) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else if (flush) begin
          w_pc_nxt = r_pc;
        end else if (!stall) begin
          w_instr_nxt   = r_buf;
          w_next_pc_nxt = w_pc_plus4;
          w_valid_nxt   = 1'b1;
          w_pc_nxt      = w_pc_plus4;
        end
      end
      default: ;
    endcase
    if (flush) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = 32'h0000_0000;
    end
  end

  // Datapath registers with async clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_buf     <= 32'h0000_0000;
      r_target  <= 32'h0000_0000;
      r_instr   <= 32'h0000_0000;
      r_next_pc <= 32'h0000_0000;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_buf     <= w_buf_nxt;
      r_target  <= w_target_nxt;
      r_instr   <= w_instr_nxt;
      r_next_pc <= w_next_pc_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instrOUT;
  logic [31:0] nextPcOUT;
  logic        validOUT;

  logic        reset2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic [31:0] instrOUT2;
  logic [31:0] nextPcOUT2;
  logic        validOUT2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instrOUT(instrOUT), .nextPcOUT(nextPcOUT), .validOUT(validOUT)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0000_0000),
    .instrOUT(instrOUT2), .nextPcOUT(nextPcOUT2), .validOUT(validOUT2)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rd;
    logic        st;
    logic        fl;
    logic        br;
    logic [31:0] tg;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] ei;
    logic [31:0] en;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rd, logic st, logic fl,
                              logic br, logic [31:0] tg, logic ereq, logic [31:0] eaddr,
                              logic [31:0] ei, logic [31:0] en, logic ev);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rd = rd; v.st = st; v.fl = fl; v.br = br; v.tg = tg;
    v.ereq = ereq; v.eaddr = eaddr; v.ei = ei; v.en = en; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rd, input logic st,
                       input logic fl, input logic br, input logic [31:0] tg);
    imem_ack = ack; imem_rdata = rd; stall = st; flush = fl;
    branch_taken = br; branch_target = tg;
  endtask

  task automatic sb_check(input string nm, input logic [31:0] ai, input logic [31:0] an,
                          input logic av);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty actual=%h", nm, ai);
    end else begin
      e = sb.pop_front();
      chk({nm, ".instr"}, ai, e.instr);
      chk({nm, ".npc"}, an, e.npc);
      chk({nm, ".valid"}, {31'd0, av}, {31'd0, e.valid});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst.instr", instrOUT, 32'h0);
    chk("rst.valid", {31'd0, validOUT}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    if (v.rst) do_reset();
    @(negedge clk);
    drive(v.ack, v.rd, v.st, v.fl, v.br, v.tg);
    #1;
    chk({nm, ".req"}, {31'd0, imem_req}, {31'd0, v.ereq});
    chk({nm, ".addr"}, imem_addr, v.eaddr);
    e.instr = v.ei; e.npc = v.en; e.valid = v.ev;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sb_check(nm, instrOUT, nextPcOUT, validOUT);
  endtask

  task automatic async_reset_chk(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, ".instr"}, instrOUT, 32'h0);
    chk({nm, ".npc"}, nextPcOUT, 32'h0);
    chk({nm, ".valid"}, {31'd0, validOUT}, 32'h0);
    chk({nm, ".req"}, {31'd0, imem_req}, 32'h1);
    chk({nm, ".addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    reset2 = 1'b1;
    imem_ack2 = 1'b0;
    imem_rdata2 = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //           rst ack rdata          st fl br target        req addr           instr          npc            v
    tv.push_back(mk(0, 1, 32'hAAAA_0001, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 32'hAAAA_0001, 32'h0000_0004, 1));
    tv.push_back(mk(0, 1, 32'hBBBB_0002, 0, 0, 0, 32'h0,        1, 32'h0000_0004, 32'hBBBB_0002, 32'h0000_0008, 1));
    tv.push_back(mk(0, 1, 32'hCCCC_0003, 0, 0, 0, 32'h0,        1, 32'h0000_0008, 32'hCCCC_0003, 32'h0000_000C, 1));
    tv.push_back(mk(1, 1, 32'hAAAA_0001, 0, 0, 0, 32'h0,        1, 32'h0000_0000, 32'hAAAA_0001, 32'h0000_0004, 1));
    tv.push_back(mk(0, 1, 32'hBBBB_0002, 0, 0, 0, 32'h0,        1, 32'h0000_0004, 32'hBBBB_0002, 32'h0000_0008, 1));
    tv.push_back(mk(0, 1, 32'hCCCC_0003, 1, 0, 0, 32'h0,        1, 32'h0000_0008, 32'hBBBB_0002, 32'h0000_0008, 1));
    tv.push_back(mk(0, 0, 32'h0,         1, 0, 0, 32'h0,        0, 32'h0000_0008, 32'hBBBB_0002, 32'h0000_0008, 1));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 32'h0000_0008, 32'hCCCC_0003, 32'h0000_000C, 1));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0043, 1, 32'h0000_000C, 32'hCCCC_0003, 32'h0000_000C, 0));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h0000_000C, 32'hCCCC_0003, 32'h0000_000C, 0));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h0000_000C, 32'hCCCC_0003, 32'h0000_000C, 0));
    tv.push_back(mk(0, 1, 32'hDDDD_0004, 0, 0, 0, 32'h0,        1, 32'h0000_000C, 32'hCCCC_0003, 32'h0000_000C, 0));
    tv.push_back(mk(0, 1, 32'hEEEE_0005, 0, 0, 0, 32'h0,        1, 32'h0000_0040, 32'hEEEE_0005, 32'h0000_0044, 1));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0080, 1, 32'h0000_0044, 32'hEEEE_0005, 32'h0000_0044, 0));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 1, 32'h0000_0100, 1, 32'h0000_0044, 32'hEEEE_0005, 32'h0000_0044, 0));
    tv.push_back(mk(0, 1, 32'hFFFF_0006, 0, 0, 0, 32'h0,        1, 32'h0000_0044, 32'hEEEE_0005, 32'h0000_0044, 0));
    tv.push_back(mk(0, 1, 32'h1111_0007, 0, 0, 0, 32'h0,        1, 32'h0000_0100, 32'h1111_0007, 32'h0000_0104, 1));
    tv.push_back(mk(0, 0, 32'h0,         1, 1, 0, 32'h0,        1, 32'h0000_0104, 32'h0000_0000, 32'h0000_0104, 0));
    tv.push_back(mk(0, 1, 32'h2222_0008, 0, 0, 0, 32'h0,        1, 32'h0000_0104, 32'h2222_0008, 32'h0000_0108, 1));
    tv.push_back(mk(0, 0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h0000_0108, 32'h2222_0008, 32'h0000_0108, 1));
    tv.push_back(mk(0, 0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h0000_0108, 32'h2222_0008, 32'h0000_0108, 0));
    tv.push_back(mk(0, 0, 32'h0,         1, 0, 0, 32'h0,        1, 32'h0000_0108, 32'h2222_0008, 32'h0000_0108, 0));
    tv.push_back(mk(0, 1, 32'h3333_0009, 0, 0, 1, 32'h0000_0200, 1, 32'h0000_0108, 32'h2222_0008, 32'h0000_0108, 0));
    tv.push_back(mk(0, 1, 32'h4444_000A, 0, 0, 0, 32'h0,        1, 32'h0000_0200, 32'h4444_000A, 32'h0000_0204, 1));
    tv.push_back(mk(0, 1, 32'h5555_000B, 1, 0, 0, 32'h0,        1, 32'h0000_0204, 32'h4444_000A, 32'h0000_0204, 1));
    tv.push_back(mk(0, 0, 32'h0,         1, 0, 1, 32'h0000_0300, 0, 32'h0000_0204, 32'h4444_000A, 32'h0000_0204, 0));
    tv.push_back(mk(0, 1, 32'h6666_000C, 0, 0, 0, 32'h0,        1, 32'h0000_0300, 32'h6666_000C, 32'h0000_0304, 1));
    tv.push_back(mk(0, 1, 32'h7777_000D, 0, 1, 0, 32'h0,        1, 32'h0000_0304, 32'h0000_0000, 32'h0000_0304, 0));
    tv.push_back(mk(0, 1, 32'h8888_000E, 0, 0, 0, 32'h0,        1, 32'h0000_0304, 32'h8888_000E, 32'h0000_0308, 1));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init.instr", instrOUT, 32'h0);
    chk("init.npc", nextPcOUT, 32'h0);
    chk("init.valid", {31'd0, validOUT}, 32'h0);
    chk("init.req", {31'd0, imem_req}, 32'h1);
    chk("init.addr", imem_addr, 32'h0);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

    // reset while parked in HOLD
    apply(mk(0, 1, 32'h9999_000F, 1, 0, 0, 32'h0, 1, 32'h0000_0308, 32'h8888_000E, 32'h0000_0308, 1), "hold_in");
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("hold.req", {31'd0, imem_req}, 32'h0);
    async_reset_chk("hold_rst");
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    chk("hold_rel.addr", imem_addr, 32'h0);
    chk("hold_rel.req", {31'd0, imem_req}, 32'h1);

    // reset while waiting in DROP, with an ack already in flight at release
    apply(mk(0, 1, 32'hAAAA_0001, 0, 0, 0, 32'h0, 1, 32'h0000_0000, 32'hAAAA_0001, 32'h0000_0004, 1), "drop_a");
    apply(mk(0, 0, 32'h0, 0, 0, 1, 32'h0000_0500, 1, 32'h0000_0004, 32'hAAAA_0001, 32'h0000_0004, 0), "drop_in");
    @(negedge clk);
    drive(1'b1, 32'hCAFE_0010, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("drop.addr", imem_addr, 32'h0000_0004);
    async_reset_chk("drop_rst");
    e.instr = 32'hCAFE_0010; e.npc = 32'h0000_0004; e.valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb_check("drop_rel", instrOUT, nextPcOUT, validOUT);
    chk("drop_rel.addr", imem_addr, 32'h0000_0004);

    // PC wrap from the top of the address space
    @(negedge clk);
    reset2 = 1'b0;
    #1;
    chk("wrap.init_addr", imem_addr2, 32'hFFFF_FFFC);
    chk("wrap.init_valid", {31'd0, validOUT2}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      imem_ack2 = 1'b1;
      imem_rdata2 = 32'hD00D_0000 + k;
      #1;
      chk($sformatf("wrap%0d.req", k), {31'd0, imem_req2}, 32'h1);
      chk($sformatf("wrap%0d.addr", k), imem_addr2, (k == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
      e.instr = 32'hD00D_0000 + k;
      e.npc = (k == 0) ? 32'h0000_0000 : 32'h0000_0004;
      e.valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sb_check($sformatf("wrap%0d", k), instrOUT2, nextPcOUT2, validOUT2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
